// File: rtl/memseq_pkg.sv
// Shared definitions for the memory access sequencer: request op codes,
// special S-register addresses and the sequencer state encoding.
package memseq_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INCR  = 2'b10,
        OP_XCH   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    localparam logic [11:0] ADDR_ZERO  = 12'h007;
    localparam logic [11:0] ADDR_LP    = 12'h008;
    localparam logic [11:0] ADDR_CYR   = 12'h010;
    localparam logic [11:0] ADDR_SR    = 12'h011;
    localparam logic [11:0] ADDR_CYL   = 12'h012;
    localparam logic [11:0] ADDR_EDOP  = 12'h013;
    localparam logic [11:0] FIXED_BASE = 12'h400;

    // Central registers live in the register file: Z..Q, G (0x000-0x006) and LP.
    function automatic logic is_central_reg(input logic [11:0] a);
        return (a < ADDR_ZERO) || (a == ADDR_LP);
    endfunction

endpackage

// File: rtl/mem_edit.sv
// Editing-register data transform applied to words stored at CYR/SR/CYL/EDOP.
// Any other address passes the data through with is_edit low.
module mem_edit (
    input  logic [11:0] addr,
    input  logic [15:0] data,
    output logic [15:0] edited_data,
    output logic        is_edit
);
    import memseq_pkg::*;

    // Select the edit by address; pass-through is the default.
    always_comb begin
        edited_data = data;
        is_edit     = 1'b1;
        case (addr)
            ADDR_CYR:  edited_data = {data[0], data[15:1]};
            ADDR_SR:   edited_data = {data[15], data[15:1]};
            ADDR_CYL:  edited_data = {data[14:0], data[15]};
            ADDR_EDOP: edited_data = {9'b0, data[13:7]};
            default:   is_edit = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Turns single-word CPU requests (READ/WRITE/INCR/XCH) into timed cycles on
// the banked memory, redirecting central-register writes to the register
// file, discarding writes to the hardwired zero and protecting fixed memory.
// Build option: FIXED_MEM_WRITE_EN makes fixed memory writable (no faults).
module mem_access_sequencer #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_fault,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic        reg_wr_en,
    output logic [3:0]  reg_wr_sel,
    output logic [15:0] reg_wr_data
);
    import memseq_pkg::*;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;    // request data, or g+1 for INCR
    logic [15:0] g_q, g_d;
    logic [15:0] stored_q, stored_d;  // word actually stored, reported for WRITE
    logic        fault_q, fault_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [15:0] edited_data;
    logic        is_edit;
    logic [15:0] mem_word;
    logic [15:0] g_capture;
    logic        wr_reg, wr_mem, wr_fault;
    logic        in_write;

    mem_edit u_edit (
        .addr        (addr_q),
        .data        (wdata_q),
        .edited_data (edited_data),
        .is_edit     (is_edit)
    );

    // Classify the latched address for the write cycle.
    always_comb begin
        wr_reg = is_central_reg(addr_q);
`ifdef FIXED_MEM_WRITE_EN
        wr_fault = 1'b0;
`else
        wr_fault = (addr_q >= FIXED_BASE);
`endif
        wr_mem    = !wr_reg && (addr_q != ADDR_ZERO) && !wr_fault;
        mem_word  = is_edit ? edited_data : wdata_q;
        g_capture = (addr_q == ADDR_ZERO) ? 16'h0000 : mem_rdata;
    end

    // State and datapath registers; reset returns to IDLE and clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            g_q      <= '0;
            stored_q <= '0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            g_q      <= g_d;
            stored_q <= stored_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath updates for each phase of an operation.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        g_d      = g_q;
        stored_d = stored_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d     = op_e'(req_op);
                    addr_d   = req_addr;
                    wdata_d  = req_data;
                    stored_d = '0;
                    fault_d  = 1'b0;
                    if (op_e'(req_op) == OP_WRITE) begin
                        state_d = ST_WRITE;
                    end else if (LAT == 3'd0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                g_d = g_capture;
                case (op_q)
                    OP_INCR: begin
                        wdata_d = g_capture + 16'd1;
                        state_d = ST_WRITE;
                    end
                    OP_XCH:  state_d = ST_WRITE;
                    default: state_d = ST_RESP;
                endcase
            end
            ST_WRITE: begin
                fault_d  = wr_fault;
                stored_d = wr_reg ? wdata_q : (wr_mem ? mem_word : 16'h0000);
                state_d  = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs; strobes are masked during reset so an aborted op issues nothing.
    always_comb begin
        in_write    = !reset && (state_q == ST_WRITE);
        req_ready   = (state_q == ST_IDLE);
        mem_addr    = addr_q;
        mem_we      = in_write && wr_mem;
        mem_wdata   = mem_we ? mem_word : 16'h0000;
        reg_wr_en   = in_write && wr_reg;
        reg_wr_sel  = reg_wr_en ? addr_q[3:0] : 4'h0;
        reg_wr_data = reg_wr_en ? wdata_q : 16'h0000;
        rsp_valid   = !reset && (state_q == ST_RESP);
        rsp_data    = !rsp_valid ? 16'h0000 : ((op_q == OP_WRITE) ? stored_q : g_q);
        rsp_fault   = rsp_valid && fault_q;
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed vector table, a reset-abort
// sequence and randomized requests against a reference model.
module tb_mem_access_sequencer;

    localparam int L = 1;
    localparam int HI = (L == 0) ? 0 : L - 1;
`ifdef FIXED_MEM_WRITE_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [15:0] req_data;
    logic        rsp_valid, rsp_fault;
    logic [15:0] rsp_data;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_we, reg_wr_en;
    logic [3:0]  reg_wr_sel;
    logic [15:0] reg_wr_data;

    mem_access_sequencer #(.READ_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data)
    );

    // Memory device: writes on the clock edge, read data L cycles after address.
    logic [15:0] mem [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [11:0] addr_hist [0:7];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [15:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        addr_hist[0] <= mem_addr;
        for (int i = 1; i < 8; i++) addr_hist[i] <= addr_hist[i-1];
    end

    always_comb mem_rdata = (L == 0) ? mem[mem_addr] : mem[addr_hist[HI]];

    typedef struct {
        logic [15:0] rsp;
        logic        fault;
        int          lat;
        int          we_cnt;
        logic [15:0] wdata;
        int          reg_cnt;
        logic [3:0]  sel;
        logic [15:0] rdata;
        logic        overlap;
        logic        moved;
        logic        timeout;
    } obs_t;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [15:0] data;
        logic        pre_en;
        logic [15:0] pre;
        logic [15:0] rsp;
        logic        fault;
        int          we;
        logic [15:0] wdata;
        int          rg;
        logic [3:0]  sel;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int n_txn = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Reference: derives every observable of one request from the rules.
    function automatic obs_t model(input logic [1:0] op, input logic [11:0] a, input logic [15:0] d);
        obs_t e;
        logic [15:0] g, w, st;
        e = '{default: 0};
        g = (a == 12'h007) ? 16'h0000 : ref_mem[a];
        w = (op == 2'b10) ? g + 16'd1 : d;
        e.lat = (op == 2'b00) ? L + 1 : (op == 2'b01) ? 1 : L + 2;
        st = 16'h0000;
        if (op != 2'b00) begin
            if (a < 12'h007 || a == 12'h008) begin
                e.reg_cnt = 1; e.sel = a[3:0]; e.rdata = w; st = w;
            end else if (a == 12'h007) begin
                st = 16'h0000;
            end else if (a >= 12'h400 && !FW) begin
                e.fault = 1'b1;
            end else begin
                case (a)
                    12'h010: st = {w[0], w[15:1]};
                    12'h011: st = {w[15], w[15:1]};
                    12'h012: st = {w[14:0], w[15]};
                    12'h013: st = {9'b0, w[13:7]};
                    default: st = w;
                endcase
                e.we_cnt = 1; e.wdata = st;
            end
        end
        e.rsp = (op == 2'b01) ? st : g;
        return e;
    endfunction

    // Issue one request and record everything seen until the response.
    task automatic run_req(input logic [1:0] op, input logic [11:0] a, input logic [15:0] d, output obs_t o);
        bit got;
        o = '{default: 0};
        @(negedge clk);
        check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (mem_we) begin o.we_cnt++; o.wdata = mem_wdata; end
            if (reg_wr_en) begin o.reg_cnt++; o.sel = reg_wr_sel; o.rdata = reg_wr_data; end
            if (mem_we && reg_wr_en) o.overlap = 1'b1;
            if (mem_addr !== a) o.moved = 1'b1;
            if (rsp_valid) begin
                got = 1'b1; o.lat = c; o.rsp = rsp_data; o.fault = rsp_fault;
            end else begin
                @(negedge clk);
            end
        end
        o.timeout = !got;
    endtask

    task automatic compare(input string tag, input logic [11:0] a, input obs_t e, input obs_t o);
        logic [15:0] new_val;
        check({tag, "_timeout"}, {31'd0, o.timeout}, 32'd0);
        check({tag, "_latency"}, o.lat, e.lat);
        check({tag, "_rsp_data"}, {16'd0, o.rsp}, {16'd0, e.rsp});
        check({tag, "_rsp_fault"}, {31'd0, o.fault}, {31'd0, e.fault});
        check({tag, "_mem_we_count"}, o.we_cnt, e.we_cnt);
        if (e.we_cnt == 1) check({tag, "_mem_wdata"}, {16'd0, o.wdata}, {16'd0, e.wdata});
        check({tag, "_reg_wr_count"}, o.reg_cnt, e.reg_cnt);
        if (e.reg_cnt == 1) begin
            check({tag, "_reg_wr_sel"}, {28'd0, o.sel}, {28'd0, e.sel});
            check({tag, "_reg_wr_data"}, {16'd0, o.rdata}, {16'd0, e.rdata});
        end
        check({tag, "_we_reg_overlap"}, {31'd0, o.overlap}, 32'd0);
        check({tag, "_mem_addr_stable"}, {31'd0, o.moved}, 32'd0);
        new_val = (e.we_cnt == 1) ? e.wdata : ref_mem[a];
        ref_mem[a] = new_val;
        check({tag, "_mem_content"}, {16'd0, mem[a]}, {16'd0, new_val});
        $display("txn %0d %s op=%0d addr=%03h rsp=%04h fault=%0d lat=%0d we=%0d reg=%0d",
                 n_txn, tag, req_op, a, o.rsp, o.fault, o.lat, o.we_cnt, o.reg_cnt);
        n_txn++;
    endtask

    vec_t vecs [13];

    initial begin
        obs_t o, e;
        logic [15:0] v;
        int bad;
        logic [1:0]  rop;
        logic [11:0] ra;
        logic [15:0] rd;

        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_data = '0;
        pl_en = 1'b1; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 4096; i++) begin
            v = 16'($urandom);
            pl_addr = 12'(i); pl_data = v; ref_mem[i] = v;
            @(negedge clk);
        end
        pl_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        reset = 1'b0;

        // op, addr, data, pre_en, pre, rsp, fault, we, wdata, rg, sel
        vecs[0]  = '{2'b00, 12'h200, 16'h0000, 1'b1, 16'h1234, 16'h1234, 1'b0, 0, 16'h0000, 0, 4'h0};
        vecs[1]  = '{2'b10, 12'h300, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1, 16'h0000, 0, 4'h0};
        vecs[2]  = '{2'b01, 12'h010, 16'h8001, 1'b0, 16'h0000, 16'hC000, 1'b0, 1, 16'hC000, 0, 4'h0};
        vecs[3]  = '{2'b01, 12'h011, 16'h8002, 1'b0, 16'h0000, 16'hC001, 1'b0, 1, 16'hC001, 0, 4'h0};
        vecs[4]  = '{2'b01, 12'h013, 16'h3F80, 1'b0, 16'h0000, 16'h007F, 1'b0, 1, 16'h007F, 0, 4'h0};
        vecs[5]  = '{2'b01, 12'h012, 16'h8001, 1'b0, 16'h0000, 16'h0003, 1'b0, 1, 16'h0003, 0, 4'h0};
        vecs[6]  = '{2'b01, 12'h003, 16'hBEEF, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 0, 16'h0000, 1, 4'h3};
        vecs[7]  = '{2'b00, 12'h007, 16'h0000, 1'b1, 16'h5555, 16'h0000, 1'b0, 0, 16'h0000, 0, 4'h0};
        vecs[8]  = '{2'b01, 12'h500, 16'h1111, 1'b0, 16'h0000, FW ? 16'h1111 : 16'h0000,
                     !FW, FW ? 1 : 0, 16'h1111, 0, 4'h0};
        vecs[9]  = '{2'b01, 12'h007, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 0, 4'h0};
        vecs[10] = '{2'b01, 12'h008, 16'h1234, 1'b0, 16'h0000, 16'h1234, 1'b0, 0, 16'h0000, 1, 4'h8};
        vecs[11] = '{2'b11, 12'h150, 16'h00AA, 1'b1, 16'h0042, 16'h0042, 1'b0, 1, 16'h00AA, 0, 4'h0};
        vecs[12] = '{2'b10, 12'h012, 16'h0000, 1'b1, 16'h4000, 16'h4000, 1'b0, 1, 16'h8002, 0, 4'h0};

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].pre_en) preload(vecs[i].addr, vecs[i].pre);
            e = '{default: 0};
            e.lat = (vecs[i].op == 2'b00) ? L + 1 : (vecs[i].op == 2'b01) ? 1 : L + 2;
            e.rsp = vecs[i].rsp; e.fault = vecs[i].fault;
            e.we_cnt = vecs[i].we; e.wdata = vecs[i].wdata;
            e.reg_cnt = vecs[i].rg; e.sel = vecs[i].sel; e.rdata = vecs[i].data;
            run_req(vecs[i].op, vecs[i].addr, vecs[i].data, o);
            compare($sformatf("vec%0d", i), vecs[i].addr, e, o);
        end

        // Reset asserted while an XCH is in CAPTURE: nothing may be issued.
        preload(12'h100, 16'h0042);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_addr = 12'h100; req_data = 16'h00AA;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (L) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (mem_we || reg_wr_en || rsp_valid) bad++;
            @(negedge clk);
            reset = 1'b0;
        end
        check("abort_no_activity", bad, 0);
        check("abort_mem_unchanged", {16'd0, mem[12'h100]}, 32'h0042);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_mem_addr", {20'd0, mem_addr}, 32'd0);
        e = model(2'b11, 12'h100, 16'h00AA);
        run_req(2'b11, 12'h100, 16'h00AA, o);
        compare("xch_retry", 12'h100, e, o);
        check("xch_retry_rsp", {16'd0, o.rsp}, 32'h0042);
        check("xch_retry_mem", {16'd0, mem[12'h100]}, 32'h00AA);

        // Randomized requests across all address classes.
        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ra = 12'($urandom_range(0, 8));
                1:       ra = 12'(16 + $urandom_range(0, 3));
                2:       ra = 12'($urandom_range(20, 1023));
                default: ra = 12'($urandom_range(1024, 4095));
            endcase
            rd = 16'($urandom);
            e = model(rop, ra, rd);
            run_req(rop, ra, rd, o);
            compare($sformatf("rnd%0d", i), ra, e, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
